// File: rtl/sort4_controller_pkg.sv
// Shared constants for the sort4 controller: element/counter widths and
// the FSM state encoding used by the controller and anything that decodes it.
package sort4_controller_pkg;

    localparam int ELEM_W = 3;
    localparam int CNT_W  = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/sort4_controller_if.sv
// Host-side bundle of the sort4 controller: request, direction and value
// vector in; working/sorted vector, status and swap count out.
interface sort4_controller_if
    import sort4_controller_pkg::*;
#(
    parameter int N = 4
);

    logic                    start;
    logic                    desc;
    logic [ELEM_W*N-1:0]     din;
    logic [ELEM_W*N-1:0]     dout;
    logic                    busy;
    logic                    done;
    logic [CNT_W-1:0]        swap_count;

    // Host side: issues sort requests and consumes results.
    modport master (
        output start, desc, din,
        input  dout, busy, done, swap_count
    );

    // Sort engine side.
    modport slave (
        input  start, desc, din,
        output dout, busy, done, swap_count
    );

endinterface

// File: rtl/sort4_controller_compare.sv
// 3-bit magnitude comparator: exactly one of greater/equal/smaller is high.
module compare_demo (
    input  logic [2:0] x,
    input  logic [2:0] y,
    output logic       xgy,
    output logic       xey,
    output logic       xsy
);

    assign xgy = (x > y);
    assign xey = (x == y);
    assign xsy = (x < y);

endmodule

// File: rtl/sort4_controller.sv
// Sequential bubble sorter: one compare-and-conditional-swap per cycle on a
// single shared comparator, with early exit after a swap-free pass.
module sort4_controller
    import sort4_controller_pkg::*;
#(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst,
    sort4_controller_if.slave  bus
);

    localparam int                IDX_W     = $clog2(N);
    localparam logic [IDX_W-1:0]  LAST_PASS = IDX_W'(N - 2);

    typedef logic [N-1:0][ELEM_W-1:0] vec_t;

    logic [1:0]        state_q, state_d;
    vec_t              r_q, r_d;
    logic [IDX_W-1:0]  i_q, i_d;
    logic [IDX_W-1:0]  pass_q, pass_d;
    logic              swapped_q, swapped_d;
    logic              mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ELEM_W-1:0] x, y;
    logic              xgy, xey, xsy;
    logic              do_swap;
    logic              pass_end;

    // Select the adjacent pair r[i], r[i+1] for the shared comparator.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        x = '0;
        y = '0;
        for (int k = 0; k < N - 1; k++) begin
            if (i_q == IDX_W'(k)) begin
                x = r_q[k];
                y = r_q[k + 1];
            end
        end
    end

    compare_demo u_cmp (
        .x   (x),
        .y   (y),
        .xgy (xgy),
        .xey (xey),
        .xsy (xsy)
    );

    // Equal elements never move, which keeps the sort stable.
    assign do_swap  = (mode_q ? xsy : xgy) & ~xey;
    assign pass_end = (i_q == (LAST_PASS - pass_q));

    // FSM and datapath next-state: load on start, compare/swap in RUN.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        i_d       = i_q;
        pass_d    = pass_q;
        swapped_d = swapped_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    r_d       = bus.din;
                    mode_d    = bus.desc;
                    i_d       = '0;
                    pass_d    = '0;
                    swapped_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_RUN;
                end
            end

            ST_RUN: begin
                if (do_swap) begin
                    for (int k = 0; k < N - 1; k++) begin
                        if (i_q == IDX_W'(k)) begin
                            r_d[k]     = y;
                            r_d[k + 1] = x;
                        end
                    end
                    swapped_d = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end

                if (pass_end) begin
                    if ((!swapped_q && !do_swap) || (pass_q == LAST_PASS)) begin
                        state_d = ST_DONE;
                    end else begin
                        pass_d    = pass_q + IDX_W'(1);
                        i_d       = '0;
                        swapped_d = 1'b0;
                    end
                end else begin
                    i_d = i_q + IDX_W'(1);
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-high reset of every register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            r_q       <= '0;
            i_q       <= '0;
            pass_q    <= '0;
            swapped_q <= 1'b0;
            mode_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            state_q   <= state_d;
            r_q       <= r_d;
            i_q       <= i_d;
            pass_q    <= pass_d;
            swapped_q <= swapped_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.dout       = r_q;
    assign bus.busy       = (state_q == ST_RUN);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.swap_count = cnt_q;

endmodule

// File: doc/sort4_controller.md
Name: sort4_controller

Overview:
- Sequential sort engine that time-shares one instance of the existing 3-bit comparator compare_demo (x, y -> xgy, xey, xsy).
- Loads N packed 3-bit values and bubble-sorts them, one compare-and-conditional-swap per cycle, with early exit on a swap-free pass.
- Sits between a host that supplies a value vector and downstream logic that consumes the sorted vector.

Parameters:
- N, 4, number of 3-bit elements; legal range 2..8.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  request a sort; accepted only in IDLE
- desc  in  1  0 = ascending, 1 = descending; sampled with an accepted start
- din  in  3*N  unsorted values; element k = din[3k+2:3k]
- dout  out  3*N  working/sorted values; element k = dout[3k+2:3k]
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse: dout holds the final result
- swap_count  out  6  swaps performed in the current or last sort

Behaviour:
- Reset (rst=1 at a clock edge, any state): state=IDLE; all element registers, i, pass, swapped, mode and swap_count cleared to 0; busy=0; done=0. An in-flight sort is abandoned with no done pulse.
- Registers:
  - r[0..N-1] (3 bits each); dout is r packed directly.
  - i = pair index; pass = pass number.
  - swapped = swap seen in the current pass; mode = latched desc.
- Comparator wiring: x=r[i], y=r[i+1], combinational, single shared instance.
- Swap condition: mode=0 -> xgy; mode=1 -> xsy. Equal values (xey) never swap; the sort is stable.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1: load r[k]=din element k, mode=desc, i=0, pass=0, swapped=0, swap_count=0; go to RUN.
  - Otherwise r holds, so dout keeps the previous result.
- RUN, one compare per cycle, busy=1:
  - If the swap condition holds: exchange r[i] and r[i+1], set swapped, increment swap_count.
  - If i = N-2-pass (pass end): if neither swapped nor this cycle's swap is set, or pass = N-2, go to DONE. Otherwise pass++, i=0, swapped=0.
  - Else i++.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start is ignored in DONE.
- start while busy or in DONE is ignored and not queued. start held high stays harmless: a new sort begins on the first IDLE cycle.
- Latency: start accepted at edge 0; K compares commit at edges 1..K; done is high in the cycle after edge K.
  - Best case (already sorted): K = N-1.
  - Worst case: K = N(N-1)/2.
- swap_count: max N(N-1)/2 = 28 fits 6 bits, so no saturation is needed. It holds its value until the next accepted start.
- din is not observed after the load edge; changes during RUN have no effect.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - element width constant ELEM_W=3;
  - swap_count width constant CNT_W=6.
- One sub-module: compare_demo, instantiated once and unmodified.
- Element array, index/pass counters and FSM stay in sort4_controller.

Test Plan:
- Sorted {0,1,2,3}, desc=0 -> 3 compares; done at edge 4; dout elements 0,1,2,3; swap_count=0.
- Reverse {7,5,3,1}, desc=0 -> 6 compares; done at edge 7; dout 1,3,5,7; swap_count=6.
- Duplicates {4,4,2,4}, desc=0 -> dout 2,4,4,4; swap_count=2; done at edge 7; equal pairs never swap.
- {1,3,5,7}, desc=1 -> dout 7,5,3,1; swap_count=6; done at edge 7.
- Reverse case with rst asserted at edge 3:
  - Next cycle: busy=0, dout=0, swap_count=0, no done pulse.
  - Fresh start afterwards completes normally.
- start pulsed during RUN with different din -> ignored; result matches the original din. start held high through DONE -> new sort begins in the following IDLE cycle with busy=1.
